booth_wallace_mac_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational Booth/Wallace multiplier in the conv1d datapath.
- Computes WIDTH_DATA x WIDTH_DATA products in a 3-stage pipeline: Booth encode, Wallace reduction, final add plus accumulate.
- Adds a per-beat signed/unsigned mode, a valid/ready handshake with backpressure, and a running accumulator with first/last framing.
- Feeds the conv1d PE array as its MAC primitive.

---
 rtl/booth_wallace_mac_pipe.sv | 195 +++++++++++++++++++
 tb/tb_booth_wallace_mac_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_wallace_mac_pipe.sv
`default_nettype none
// ============================================================================
// booth_wallace_mac_pipe : 3-stage radix-4 Booth / Wallace MAC with framed
// accumulation; define BOOTH_MAC_SATURATE_EN for saturating accumulation.
// Revision: 1.0
// ============================================================================
module booth_wallace_mac_pipe #(
  parameter int WIDTH_DATA = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_DATA-1:0] weight,
  input  logic [WIDTH_DATA-1:0] feature,
  input  logic                  signed_mode,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  result_out,
  output logic                  sat_flag
);

  localparam int EW  = WIDTH_DATA + 1;
  localparam int NPP = WIDTH_DATA / 2 + 1;
  localparam int PW  = 2 * WIDTH_DATA + 2;
  localparam int MW  = 2 * WIDTH_DATA + 1;

  generate
    if (ACC_WIDTH < 2 * WIDTH_DATA + 1) begin : g_acc_width_check
      $error("ACC_WIDTH must be >= 2*WIDTH_DATA+1");
    end
    if ((WIDTH_DATA % 2) != 0 || WIDTH_DATA < 4) begin : g_width_check
      $error("WIDTH_DATA must be even and >= 4");
    end
  endgenerate

  logic                 r_v1, r_first1, r_last1;
  logic [PW-1:0]        r_pp1 [NPP];
  logic                 r_v2, r_first2, r_last2;
  logic [PW-1:0]        r_sum2, r_carry2;
  logic [ACC_WIDTH-1:0] r_acc, r_result;
  logic                 r_out_valid;

  logic w_stall;
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;

  // Stage 1: extend operands per mode, radix-4 Booth recode of the multiplier.
  logic [EW-1:0]    w_a_ext, w_b_ext;
  logic [2*NPP:0]   w_bb;
  logic [PW-1:0]    w_a_pw;
  logic [PW-1:0]    w_pp [NPP];

  assign w_a_ext = {signed_mode & weight[WIDTH_DATA-1], weight};
  assign w_b_ext = {signed_mode & feature[WIDTH_DATA-1], feature};
  assign w_bb    = {{(2*NPP-EW){w_b_ext[EW-1]}}, w_b_ext, 1'b0};
  assign w_a_pw  = {{(PW-EW){w_a_ext[EW-1]}}, w_a_ext};

  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      case (w_bb[2*i +: 3])
        3'b001, 3'b010: w_pp[i] = w_a_pw;
        3'b011:         w_pp[i] = w_a_pw << 1;
        3'b100:         w_pp[i] = -(w_a_pw << 1);
        3'b101, 3'b110: w_pp[i] = -w_a_pw;
        default:        w_pp[i] = '0;
      endcase
      w_pp[i] = w_pp[i] << (2 * i);
    end
  end

  // Stage 2: layered 3:2 compression until two rows remain.
  logic [PW-1:0] w_sum, w_carry;

  always_comb begin
    logic [PW-1:0] ops [NPP];
    logic [PW-1:0] nxt [NPP];
    int n, g, r;
    ops = r_pp1;
    nxt = r_pp1;
    n   = NPP;
    g   = 0;
    r   = 0;
    for (int lvl = 0; lvl < NPP; lvl++) begin
      if (n > 2) begin
        g = n / 3;
        r = n - 3 * g;
        for (int k = 0; k < NPP; k++) nxt[k] = '0;
        for (int k = 0; k < NPP / 3; k++) begin
          if (k < g) begin
            nxt[2*k]   = ops[3*k] ^ ops[3*k+1] ^ ops[3*k+2];
            nxt[2*k+1] = ((ops[3*k] & ops[3*k+1]) | (ops[3*k] & ops[3*k+2]) |
                          (ops[3*k+1] & ops[3*k+2])) << 1;
          end
        end
        for (int j = 0; j < 2; j++) begin
          if (j < r) nxt[2*g+j] = ops[3*g+j];
        end
        ops = nxt;
        n   = 2 * g + r;
      end
    end
    w_sum   = ops[0];
    w_carry = ops[1];
  end

  // Stage 3: the true product always fits in MW signed bits for either mode.
  logic [PW-1:0]        w_total;
  logic                 w_unused_msb;
  logic [ACC_WIDTH-1:0] w_prod, w_acc_next;

  assign w_total      = r_sum2 + r_carry2;
  assign w_unused_msb = w_total[PW-1];
  assign w_prod       = {{(ACC_WIDTH-MW){w_total[MW-1]}}, w_total[MW-1:0]};

`ifdef BOOTH_MAC_SATURATE_EN
  logic [ACC_WIDTH:0] w_wide;
  logic               w_ovf, w_sat_next;
  logic               r_sat, r_sat_out;

  assign w_wide = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod[ACC_WIDTH-1], w_prod};
  assign w_ovf  = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

  always_comb begin
    w_acc_next = w_wide[ACC_WIDTH-1:0];
    w_sat_next = r_sat;
    if (r_first2) begin
      w_acc_next = w_prod;
      w_sat_next = 1'b0;
    end else if (w_ovf) begin
      w_acc_next = w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      w_sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat     <= 1'b0;
      r_sat_out <= 1'b0;
    end else if (!w_stall && r_v2) begin
      r_sat <= w_sat_next;
      if (r_last2) r_sat_out <= w_sat_next;
    end
  end

  assign sat_flag = r_sat_out;
`else
  assign w_acc_next = r_first2 ? w_prod : r_acc + w_prod;
  assign sat_flag   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_first1    <= 1'b0;
      r_last1     <= 1'b0;
      for (int i = 0; i < NPP; i++) r_pp1[i] <= '0;
      r_v2        <= 1'b0;
      r_first2    <= 1'b0;
      r_last2     <= 1'b0;
      r_sum2      <= '0;
      r_carry2    <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_v1     <= in_valid;
      r_first1 <= acc_first;
      r_last1  <= acc_last;
      r_pp1    <= w_pp;
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_sum2   <= w_sum;
      r_carry2 <= w_carry;
      if (r_v2) r_acc <= w_acc_next;
      // A completing last beat re-arms out_valid in the same cycle it is consumed.
      if (r_v2 && r_last2) begin
        r_out_valid <= 1'b1;
        r_result    <= w_acc_next;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign result_out = r_result;

endmodule
`default_nettype wire

// File: tb/tb_booth_wallace_mac_pipe.sv
`default_nettype none
// tb_booth_wallace_mac_pipe : directed vectors, queue scoreboard with decoupled monitors.
// Second instance uses ACC_WIDTH=17 for the accumulation-overflow case.
module tb_booth_wallace_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  weight = '0, feature = '0;
  logic        signed_mode = 1'b0, acc_first = 1'b0, acc_last = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] result_out;
  logic        sat_flag;

  logic        s_in_valid = 1'b0, s_in_ready;
  logic [7:0]  s_weight = '0, s_feature = '0;
  logic        s_signed_mode = 1'b0, s_acc_first = 1'b0, s_acc_last = 1'b0;
  logic        s_out_valid, s_out_ready = 1'b1;
  logic [16:0] s_result_out;
  logic        s_sat_flag;

  typedef struct {
    logic [31:0] res;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  booth_wallace_mac_pipe #(.WIDTH_DATA(8), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .weight(weight), .feature(feature), .signed_mode(signed_mode),
    .acc_first(acc_first), .acc_last(acc_last), .out_valid(out_valid),
    .out_ready(out_ready), .result_out(result_out), .sat_flag(sat_flag)
  );

  booth_wallace_mac_pipe #(.WIDTH_DATA(8), .ACC_WIDTH(17)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .weight(s_weight), .feature(s_feature), .signed_mode(s_signed_mode),
    .acc_first(s_acc_first), .acc_last(s_acc_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .result_out(s_result_out), .sat_flag(s_sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Main-instance monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      compared++;
      if (q1.size() == 0) begin
        mismatched++;
        $display("FAIL main_unexpected_out: got result=%0d, expected no output", $signed(result_out));
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (result_out !== e.res || sat_flag !== e.sat) begin
          mismatched++;
          $display("FAIL main_result: got result=%0d sat=%0b, expected result=%0d sat=%0b",
                   $signed(result_out), sat_flag, $signed(e.res), e.sat);
        end
        if (e.cyc >= 0) begin
          compared++;
          if (cyc != e.cyc) begin
            mismatched++;
            $display("FAIL main_latency: got out at cycle %0d, expected cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  // Narrow-instance monitor
  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      compared++;
      if (q2.size() == 0) begin
        mismatched++;
        $display("FAIL narrow_unexpected_out: got result=%0d, expected no output", $signed(s_result_out));
      end else begin
        exp_t e;
        e = q2.pop_front();
        if ({{15{s_result_out[16]}}, s_result_out} !== e.res || s_sat_flag !== e.sat) begin
          mismatched++;
          $display("FAIL narrow_result: got result=%0d sat=%0b, expected result=%0d sat=%0b",
                   $signed(s_result_out), s_sat_flag, $signed(e.res), e.sat);
        end
      end
    end
  end

  // Offer one beat, hold it until accepted, queue the expectation on a last beat.
  task automatic send(input bit sel, input logic [7:0] w, input logic [7:0] f,
                      input logic sm, input logic first, input logic last,
                      input logic [31:0] er, input logic es, input bit chk_lat);
    int  n;
    bit  rdy;
    exp_t e;
    if (!sel) begin
      in_valid = 1'b1; weight = w; feature = f; signed_mode = sm;
      acc_first = first; acc_last = last;
    end else begin
      s_in_valid = 1'b1; s_weight = w; s_feature = f; s_signed_mode = sm;
      s_acc_first = first; s_acc_last = last;
    end
    n = 0;
    forever begin
      @(negedge clk);
      rdy = sel ? s_in_ready : in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        break;
      end
    end
    #1;
    if (!sel) in_valid = 1'b0;
    else      s_in_valid = 1'b0;
    if (last) begin
      e.res = er;
      e.sat = es;
      e.cyc = chk_lat ? cyc + 2 : -1;
      if (!sel) q1.push_back(e);
      else      q2.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || out_valid || s_out_valid) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 60) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q1.size(), q2.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic es_narrow;
    logic [31:0] er_narrow;
`ifdef BOOTH_MAC_SATURATE_EN
    er_narrow = 32'd65535;
    es_narrow = 1'b1;
`else
    er_narrow = 32'(-50427);
    es_narrow = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result_out, 32'd0);
    chk("reset_sat", {31'd0, sat_flag}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single-beat frames, extreme operands in both modes
    send(0, 8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 32'd16384, 1'b0, 1'b1);
    drain();
    send(0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 32'd65025, 1'b0, 1'b1);
    send(0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0);
    send(0, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b1, 32'd32640, 1'b0, 1'b0);
    send(0, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b1, 32'(-16256), 1'b0, 1'b0);
    drain();

    // Three-beat signed frame: 12 - 10 + 49
    send(0, 8'd3, 8'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    send(0, 8'hFE, 8'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    send(0, 8'd7, 8'd7, 1'b1, 1'b0, 1'b1, 32'd51, 1'b0, 1'b0);
    drain();

    // Backpressure: four results held back for six cycles
    out_ready = 1'b0;
    fork
      begin
        send(0, 8'd1, 8'd2, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
        send(0, 8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        send(0, 8'd5, 8'd6, 1'b1, 1'b1, 1'b1, 32'd30, 1'b0, 1'b0);
        send(0, 8'd7, 8'd8, 1'b1, 1'b1, 1'b1, 32'd56, 1'b0, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-frame: in-flight beats and accumulator are discarded
    send(0, 8'd9, 8'd9, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    send(0, 8'd9, 8'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(0, 8'd5, 8'd5, 1'b1, 1'b0, 1'b1, 32'd25, 1'b0, 1'b0);
    send(0, 8'd2, 8'd3, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0);
    drain();

    // Five 127*127 beats into the 17-bit accumulator
    for (int i = 0; i < 5; i++) begin
      send(1, 8'h7F, 8'h7F, 1'b1, (i == 0), (i == 4), er_narrow, es_narrow, 1'b0);
    end
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("final_q1_empty", q1.size(), 32'd0);
    chk("final_q2_empty", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
